// File: rtl/miner_nonce_scheduler.sv
// miner_nonce_scheduler: shares one nonce range across miner cores, records the first hit, drains in-flight cores
module miner_nonce_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W = 32
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NONCE_W-1:0]             nonce_start,
  input  logic [NONCE_W-1:0]             nonce_end,
  input  logic [NUM_CORES-1:0]           core_finished,
  input  logic [NUM_CORES-1:0]           core_hit,
  output logic [NUM_CORES-1:0]           core_hash_enable,
  output logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic [NONCE_W-1:0]             found_nonce,
  output logic                           exhausted
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] IDLE = 2'd0, DISPATCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [NUM_CORES-1:0] core_busy, hits;
  logic [NONCE_W-1:0] next_nonce, end_nonce;
  logic [IW-1:0] free_idx, hit_idx;
  logic any_free, last;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign hits = core_finished & core_hit & core_busy;
  assign any_free = ~&core_busy;
  assign last = next_nonce == end_nonce;
  // lowest-index idle core and lowest-index hitting core
  always_comb begin
    free_idx = '0;
    hit_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!core_busy[i]) free_idx = IW'(i);
      if (hits[i]) hit_idx = IW'(i);
    end
  end
  // job FSM: dispatch one idle core per cycle, stop on hit, last nonce or abort, then drain
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      core_busy <= '0;
      next_nonce <= '0;
      end_nonce <= '0;
      core_hash_enable <= '0;
      core_nonce <= '0;
      found <= 1'b0;
      found_nonce <= '0;
      exhausted <= 1'b0;
    end else begin
      core_hash_enable <= '0;
      core_busy <= core_busy & ~core_finished;
      if (|hits && !found) begin
        found <= 1'b1;
        found_nonce <= core_nonce[hit_idx*NONCE_W +: NONCE_W];
      end
      case (state)
        IDLE: if (start) begin
          next_nonce <= nonce_start;
          end_nonce <= nonce_end;
          found <= 1'b0;
          found_nonce <= '0;
          exhausted <= nonce_start > nonce_end;
          state <= nonce_start > nonce_end ? DRAIN : DISPATCH;
        end
        DISPATCH: if (abort) state <= DRAIN;
        else begin
          if (any_free) begin
            core_hash_enable[free_idx] <= 1'b1;
            core_nonce[free_idx*NONCE_W +: NONCE_W] <= next_nonce;
            core_busy[free_idx] <= 1'b1;
            next_nonce <= next_nonce + 1'b1;
            exhausted <= last;
          end
          if ((any_free && last) || |hits) state <= DRAIN;
        end
        DRAIN: if (core_busy == '0) state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// tb_miner_nonce_scheduler: scoreboard bench for the nonce scheduler
module tb_miner_nonce_scheduler;
  localparam int NC = 4;
  localparam int NW = 32;
  logic clk = 0;
  logic n_rst = 0;
  logic start = 0;
  logic abort = 0;
  logic [NW-1:0] nonce_start = '0;
  logic [NW-1:0] nonce_end = '0;
  logic [NC-1:0] core_finished = '0;
  logic [NC-1:0] core_hit = '0;
  logic [NC-1:0] core_hash_enable;
  logic [NC*NW-1:0] core_nonce;
  logic busy, done, found, exhausted;
  logic [NW-1:0] found_nonce;
  typedef struct {
    bit kind;
    int core;
    logic [NW-1:0] nonce;
    bit f;
    logic [NW-1:0] fn;
    bit ex;
  } ev_t;
  ev_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  miner_nonce_scheduler #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .core_finished(core_finished), .core_hit(core_hit),
    .core_hash_enable(core_hash_enable), .core_nonce(core_nonce),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
    .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [NW-1:0] act, logic [NW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_d(int c, logic [NW-1:0] n);
    ev_t e;
    e.kind = 0; e.core = c; e.nonce = n; e.f = 0; e.fn = '0; e.ex = 0;
    q.push_back(e);
  endtask

  task automatic push_done(bit f, logic [NW-1:0] fn, bit ex);
    ev_t e;
    e.kind = 1; e.core = 0; e.nonce = '0; e.f = f; e.fn = fn; e.ex = ex;
    q.push_back(e);
  endtask

  task automatic go(logic [NW-1:0] s, logic [NW-1:0] e);
    nonce_start = s;
    nonce_end = e;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic fin(logic [NC-1:0] f, logic [NC-1:0] h);
    core_finished = f;
    core_hit = h;
    tick();
    core_finished = '0;
    core_hit = '0;
  endtask

  task automatic wait_idle(string name);
    for (int k = 0; k < 50 && busy; k++) tick();
    check(name, {31'b0, busy}, 0);
  endtask

  // monitor: every enable pulse or done pulse consumes the next expected event
  always @(negedge clk) if (n_rst) begin
    for (int c = 0; c < NC; c++) if (core_hash_enable[c]) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_enable: got pulse on core %0d nonce %h required none", c, core_nonce[c*NW +: NW]);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("event_kind_enable", 0, {31'b0, e.kind});
        check("enable_core", c, e.core);
        check("enable_nonce", core_nonce[c*NW +: NW], e.nonce);
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done required none");
      end else begin
        ev_t e;
        e = q.pop_front();
        check("event_kind_done", 1, {31'b0, e.kind});
        check("done_found", {31'b0, found}, {31'b0, e.f});
        check("done_found_nonce", found_nonce, e.fn);
        check("done_exhausted", {31'b0, exhausted}, {31'b0, e.ex});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_found", {31'b0, found}, 0);
    check("rst_exhausted", {31'b0, exhausted}, 0);
    check("rst_enable", {28'b0, core_hash_enable}, 0);
    check("rst_nonce_any", {31'b0, |core_nonce}, 0);
    @(negedge clk);
    #1 n_rst = 1;
    tick();
    // two-nonce range: cores 0 and 1, then exhaustion
    push_d(0, 32'h10); push_d(1, 32'h11); push_done(0, '0, 1);
    go(32'h10, 32'h11);
    ticks(2);
    check("t1_exhausted", {31'b0, exhausted}, 1);
    ticks(2);
    fin(4'b0011, 4'b0000);
    wait_idle("t1_idle");
    // hit on core 2 stops dispatch; done waits for the rest
    push_d(0, 0); push_d(1, 1); push_d(2, 2); push_d(3, 3); push_done(1, 32'h2, 0);
    go(32'h0, 32'h13);
    ticks(4);
    fin(4'b0100, 4'b0100);
    check("t2_found", {31'b0, found}, 1);
    check("t2_found_nonce", found_nonce, 32'h2);
    ticks(3);
    check("t2_still_busy", {31'b0, busy}, 1);
    fin(4'b1011, 4'b0000);
    wait_idle("t2_idle");
    // simultaneous hits: lowest index wins, later hit ignored
    push_d(0, 32'h100); push_d(1, 32'h101); push_d(2, 32'h102); push_d(3, 32'h103); push_done(1, 32'h100, 0);
    go(32'h100, 32'h1ff);
    check("t3_found_cleared", {31'b0, found}, 0);
    ticks(4);
    fin(4'b1001, 4'b1001);
    check("t3_found_nonce", found_nonce, 32'h100);
    fin(4'b0010, 4'b0010);
    check("t3_found_nonce_held", found_nonce, 32'h100);
    fin(4'b0100, 4'b0000);
    wait_idle("t3_idle");
    // top of range: no wrap to nonce 0
    push_d(0, 32'hffff_fffe); push_d(1, 32'hffff_ffff); push_done(0, '0, 1);
    go(32'hffff_fffe, 32'hffff_ffff);
    ticks(4);
    check("t4_exhausted", {31'b0, exhausted}, 1);
    fin(4'b0011, 4'b0000);
    wait_idle("t4_idle");
    // empty range
    push_done(0, '0, 1);
    go(32'h5, 32'h4);
    check("t4b_exhausted", {31'b0, exhausted}, 1);
    wait_idle("t4b_idle");
    // redispatch of a freed core, then abort
    push_d(0, 32'h20); push_d(1, 32'h21); push_d(2, 32'h22); push_d(3, 32'h23); push_d(1, 32'h24); push_done(0, '0, 0);
    go(32'h20, 32'h2f);
    check("t5_exhausted_cleared", {31'b0, exhausted}, 0);
    ticks(4);
    fin(4'b0010, 4'b0000);
    tick();
    check("t5_core1_nonce", core_nonce[1*NW +: NW], 32'h24);
    abort = 1;
    tick();
    abort = 0;
    ticks(3);
    check("t5_draining", {31'b0, busy}, 1);
    check("t5_no_done", {31'b0, done}, 0);
    fin(4'b1111, 4'b0000);
    wait_idle("t5_idle");
    // reset mid-dispatch, then a fresh job
    push_d(0, 32'h40); push_d(1, 32'h41);
    go(32'h40, 32'h4f);
    ticks(2);
    @(negedge clk);
    #1 n_rst = 0;
    #1;
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_enable", {28'b0, core_hash_enable}, 0);
    check("t6_nonce_any", {31'b0, |core_nonce}, 0);
    check("t6_exhausted", {31'b0, exhausted}, 0);
    tick();
    n_rst = 1;
    tick();
    push_d(0, 32'h7); push_done(0, '0, 1);
    go(32'h7, 32'h7);
    ticks(2);
    fin(4'b0001, 4'b0000);
    wait_idle("t6_idle");
    ticks(3);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
